// File: rtl/aska_spi_frame_rx.sv
// aska_spi_frame_rx
//   SPI mode-0 slave frame receiver and configuration register file for the
//   ASKA stimulator core. A write frame is one CS-low window that carries an
//   ADDR_W-bit address and then a DATA_W-bit data word, MSB first. On CS
//   release the word is committed to conf0/conf1/ele1/ele2, or the frame is
//   rejected. The SPI pins are oversampled on clk, which must run at least
//   4x SPI_Clk. There is no SPI clock domain.
//
// Ports
//   clk, reset_l          system clock, synchronous active-low reset
//   SPI_CS/Clk/MOSI       asynchronous SPI slave pins (CS active-low)
//   conf0, conf1          registers at address 0x00 / 0x01
//   ele1, ele2            electrode masks at address 0x02 / 0x03
//   wr_strobe             one-clk pulse per successful commit
//   wr_addr               address of the last commit (held)
//   frame_error           one-clk pulse per rejected frame
//   busy                  frame in progress (RX or FULL)
module aska_spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 4
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              SPI_CS,
  input  logic              SPI_Clk,
  input  logic              SPI_MOSI,
  output logic [DATA_W-1:0] conf0,
  output logic [DATA_W-1:0] conf1,
  output logic [DATA_W-1:0] ele1,
  output logic [DATA_W-1:0] ele2,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_error,
  output logic              busy
);

  // Fewer than two synchronizer flops is not metastability-safe, so clamp.
  localparam int SS      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FRAME_W);
  localparam logic [ADDR_W:0]   REG_LIM  = (ADDR_W + 1)'(NUM_REGS);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

  typedef enum logic [1:0] {IDLE, RX, FULL} state_t;

  // Pin synchronizers and edge history
  // These flops are left out of reset on purpose: they keep tracking the pins
  // while reset_l is low. If CS is still low when reset releases, no cs_fall is
  // seen, so a frame that reset interrupted cannot restart halfway through.
  logic [SS-1:0] cs_sync, sck_sync, mosi_sync;
  logic          cs_d, sck_d;

  always_ff @(posedge clk) begin
    cs_sync   <= {cs_sync[SS-2:0],   SPI_CS};
    sck_sync  <= {sck_sync[SS-2:0],  SPI_Clk};
    mosi_sync <= {mosi_sync[SS-2:0], SPI_MOSI};
    cs_d      <= cs_sync[SS-1];
    sck_d     <= sck_sync[SS-1];
  end

  logic cs_s, sck_s, mosi_s;
  logic cs_fall, cs_rise, sck_rise;

  assign cs_s     = cs_sync[SS-1];
  assign sck_s    = sck_sync[SS-1];
  assign mosi_s   = mosi_sync[SS-1];
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign sck_rise = ~sck_d & sck_s;

  // Frame receiver and register file
  state_t                             state;
  logic [FRAME_W-1:0]                 sr;
  logic [CNT_W-1:0]                   bitcnt;
  logic                               ovf;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs;

  frame_t fr;
  logic   commit_ok;

  assign fr        = frame_t'(sr);
  assign commit_ok = (bitcnt == FULL_CNT) && !ovf && ({1'b0, fr.addr} < REG_LIM);

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state       <= IDLE;
      sr          <= '0;
      bitcnt      <= '0;
      ovf         <= 1'b0;
      regs        <= '0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_strobe   <= 1'b0;
      frame_error <= 1'b0;
      // cs_rise takes priority over a coincident sck_rise. That SCK edge is
      // dropped, and the frame is judged on the bits already shifted in.
      if (state != IDLE && cs_rise) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (commit_ok) begin
          for (int i = 0; i < NUM_REGS; i++)
            if ({1'b0, fr.addr} == (ADDR_W + 1)'(i)) regs[i] <= fr.data;
          wr_strobe <= 1'b1;
          wr_addr   <= fr.addr;
        end else begin
          frame_error <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            bitcnt <= '0;
            ovf    <= 1'b0;
            state  <= RX;
            busy   <= 1'b1;
          end
          RX: if (sck_rise) begin
            sr     <= {sr[FRAME_W-2:0], mosi_s};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == FULL_CNT - 1'b1) state <= FULL;
          end
          // The shift register is frozen here. Any extra clocks mark the
          // frame as over-length so that the commit rejects it.
          FULL: if (sck_rise) ovf <= 1'b1;
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Fixed output map; addresses beyond NUM_REGS read as zero.
  logic [3:0][DATA_W-1:0] reg_view;

  for (genvar i = 0; i < 4; i++) begin : g_view
    if (i < NUM_REGS) begin : g_reg
      assign reg_view[i] = regs[i];
    end else begin : g_zero
      assign reg_view[i] = '0;
    end
  end

  assign conf0 = reg_view[0];
  assign conf1 = reg_view[1];
  assign ele1  = reg_view[2];
  assign ele2  = reg_view[3];

endmodule
